// File: rtl/reg_alu_datapath_pkg.sv
// datapath_pkg: constants shared by the 8-bit register/ALU datapath.
//   DATA_W   - data path width (8)
//   ADDR_W   - register address width (3)
//   REG_N    - number of registers (8)
//   ALU_*    - ALUOP encodings; 3'b100..3'b111 are reserved and produce zero.
package datapath_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int REG_N  = 1 << ADDR_W;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
endpackage

// File: rtl/reg_alu_datapath_if.sv
// reg_alu_datapath_if: control/data bundle between the CPU control/decode
// logic (master) and the execution datapath (slave).
//   WRITEENABLE, WRITEREG          - write-back control
//   READREG1, READREG2             - source register addresses
//   IMMEDIATE, ALUOP               - immediate operand, ALU function
//   signSelect, immSelect          - negation and operand-2 mux selects
//   REGOUT1, REGOUT2, ALURESULT    - combinational datapath outputs
interface reg_alu_datapath_if;
  import datapath_pkg::*;

  logic              WRITEENABLE;
  logic [ADDR_W-1:0] WRITEREG;
  logic [ADDR_W-1:0] READREG1;
  logic [ADDR_W-1:0] READREG2;
  logic [DATA_W-1:0] IMMEDIATE;
  logic [2:0]        ALUOP;
  logic              signSelect;
  logic              immSelect;
  logic [DATA_W-1:0] REGOUT1;
  logic [DATA_W-1:0] REGOUT2;
  logic [DATA_W-1:0] ALURESULT;

  modport master (
    output WRITEENABLE, WRITEREG, READREG1, READREG2, IMMEDIATE, ALUOP,
           signSelect, immSelect,
    input  REGOUT1, REGOUT2, ALURESULT
  );

  modport slave (
    input  WRITEENABLE, WRITEREG, READREG1, READREG2, IMMEDIATE, ALUOP,
           signSelect, immSelect,
    output REGOUT1, REGOUT2, ALURESULT
  );
endinterface

// File: rtl/reg_alu_datapath_regbank_8x8.sv
// regbank_8x8: 8 x 8-bit register storage.
//   CLK, RESET      - clock; synchronous active-high clear of all registers
//   we/waddr/wdata  - synchronous write port (reset has priority)
//   raddr1/rdata1   - asynchronous read port 1
//   raddr2/rdata2   - asynchronous read port 2
// Optional macro DATAPATH_SIM_DELAY_EN adds simulation-only delays
// (read #2, write #1 after the edge); cycle behaviour is unchanged.
module regbank_8x8
  import datapath_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [REG_N];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (we) begin
`ifdef DATAPATH_SIM_DELAY_EN
      regs[waddr] <= #1 wdata;
`else
      regs[waddr] <= wdata;
`endif
    end
  end

`ifdef DATAPATH_SIM_DELAY_EN
  assign #2 rdata1 = regs[raddr1];
  assign #2 rdata2 = regs[raddr2];
`else
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
`endif

endmodule

// File: rtl/reg_alu_datapath.sv
// reg_alu_datapath: 8-bit execution datapath (register file, negation,
// operand muxes, 4-function ALU with write-back).
//   CLK    - clock, all state changes on the rising edge
//   RESET  - synchronous active-high; clears all registers, overrides writes
//   bus    - reg_alu_datapath_if.slave: selects/opcode/enable in,
//            REGOUT1/REGOUT2/ALURESULT out (purely combinational)
// Optional macro DATAPATH_SIM_DELAY_EN adds simulation-only delays
// (negation #1, FORWARD #1, ADD/AND/OR #2); zero-delay otherwise.
module reg_alu_datapath
  import datapath_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  reg_alu_datapath_if.slave     bus
);

  logic [DATA_W-1:0]        regout1;
  logic [DATA_W-1:0]        regout2;
  logic signed [DATA_W-1:0] neg_val;
  logic [DATA_W-1:0]        reg_path;
  logic [DATA_W-1:0]        operand2;
  logic [DATA_W-1:0]        res_fwd;
  logic [DATA_W-1:0]        res_add;
  logic [DATA_W-1:0]        res_and;
  logic [DATA_W-1:0]        res_or;
  logic [DATA_W-1:0]        alu_result;

  regbank_8x8 u_regbank (
    .CLK    (CLK),
    .RESET  (RESET),
    .we     (bus.WRITEENABLE),
    .waddr  (bus.WRITEREG),
    .wdata  (alu_result),
    .raddr1 (bus.READREG1),
    .raddr2 (bus.READREG2),
    .rdata1 (regout1),
    .rdata2 (regout2)
  );

  // Two's-complement negation wraps mod 256, so -0x80 stays 0x80.
`ifdef DATAPATH_SIM_DELAY_EN
  assign #1 neg_val = -$signed(regout2);
`else
  assign neg_val = -$signed(regout2);
`endif

  assign reg_path = bus.signSelect ? $unsigned(neg_val) : regout2;
  assign operand2 = bus.immSelect ? bus.IMMEDIATE : reg_path;

`ifdef DATAPATH_SIM_DELAY_EN
  assign #1 res_fwd = operand2;
  assign #2 res_add = regout1 + operand2;
  assign #2 res_and = regout1 & operand2;
  assign #2 res_or  = regout1 | operand2;
`else
  assign res_fwd = operand2;
  assign res_add = regout1 + operand2;
  assign res_and = regout1 & operand2;
  assign res_or  = regout1 | operand2;
`endif

  always_comb begin
    alu_result = '0;
    case (bus.ALUOP)
      ALU_FWD: alu_result = res_fwd;
      ALU_ADD: alu_result = res_add;
      ALU_AND: alu_result = res_and;
      ALU_OR:  alu_result = res_or;
      default: alu_result = '0;
    endcase
  end

  assign bus.REGOUT1   = regout1;
  assign bus.REGOUT2   = regout2;
  assign bus.ALURESULT = alu_result;

endmodule

// File: tb/tb_reg_alu_datapath.sv
module tb_reg_alu_datapath;
  import datapath_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  int   n_total = 0;
  int   n_pass  = 0;

  reg_alu_datapath_if bus ();

  reg_alu_datapath dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Reference register contents, kept as plain integers.
  int model_regs [8];
  bit model_valid = 1'b0;

  function automatic int model_alu(int op, int a, int b_reg, int imm, bit sgn, bit isel);
    int b;
    b = sgn ? ((256 - b_reg) % 256) : b_reg;
    if (isel) b = imm;
    case (op)
      0: return b;
      1: return (a + b) % 256;
      2: return a & b;
      3: return a | b;
      default: return 0;
    endcase
  endfunction

  function automatic int model_result();
    return model_alu(int'(bus.ALUOP), model_regs[bus.READREG1], model_regs[bus.READREG2],
                     int'(bus.IMMEDIATE), bus.signSelect, bus.immSelect);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model advances on the same edge as the DUT, using pre-edge inputs.
  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) model_regs[i] = 0;
      model_valid = 1'b1;
    end else if (model_valid && bus.WRITEENABLE) begin
      model_regs[bus.WRITEREG] = model_result();
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge CLK) begin
    if (model_valid && RESET === 1'b0) begin
      chk("regout1_model", bus.REGOUT1, 8'(model_regs[bus.READREG1]));
      chk("regout2_model", bus.REGOUT2, 8'(model_regs[bus.READREG2]));
      chk("aluresult_model", bus.ALURESULT, 8'(model_result()));
    end
  end

  // Apply one set of inputs just after the falling edge.
  task automatic set_in(input bit rst, input bit we, input int wr, input int r1, input int r2,
                        input int imm, input int op, input bit sgn, input bit isel);
    @(negedge CLK);
    #1;
    RESET           = rst;
    bus.WRITEENABLE = we;
    bus.WRITEREG    = 3'(wr);
    bus.READREG1    = 3'(r1);
    bus.READREG2    = 3'(r2);
    bus.IMMEDIATE   = 8'(imm);
    bus.ALUOP       = 3'(op);
    bus.signSelect  = sgn;
    bus.immSelect   = isel;
    #1;
  endtask

  task automatic load_imm(input int wr, input int imm);
    set_in(0, 1, wr, 0, 0, imm, 0, 0, 1);
  endtask

  initial begin
    RESET = 1'b0;
    bus.WRITEENABLE = 1'b0; bus.WRITEREG = '0; bus.READREG1 = '0; bus.READREG2 = '0;
    bus.IMMEDIATE = '0; bus.ALUOP = '0; bus.signSelect = 1'b0; bus.immSelect = 1'b0;

    // Reset, then sweep all addresses
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, i, 7 - i, 0, 0, 0, 0);
      chk("reset_rd1", bus.REGOUT1, 8'h00);
      chk("reset_rd2", bus.REGOUT2, 8'h00);
    end

    // Reset beats a simultaneous write
    load_imm(1, 8'h11);
    set_in(1, 1, 3, 0, 0, 8'hAA, 0, 0, 1);
    set_in(0, 0, 0, 3, 1, 0, 0, 0, 0);
    chk("reset_over_we_r3", bus.REGOUT1, 8'h00);
    chk("reset_over_we_r1", bus.REGOUT2, 8'h00);

    // Load immediates
    load_imm(1, 8'h05);
    load_imm(2, 8'h07);
    set_in(0, 0, 0, 1, 2, 0, 0, 0, 0);
    chk("load_r1", bus.REGOUT1, 8'h05);
    chk("load_r2", bus.REGOUT2, 8'h07);

    // ADD r3 = r1 + r2
    set_in(0, 1, 3, 1, 2, 0, 1, 0, 0);
    chk("add_result", bus.ALURESULT, 8'h0C);
    // SUB r4 = r1 - r2
    set_in(0, 1, 4, 1, 2, 0, 1, 1, 0);
    chk("sub_result", bus.ALURESULT, 8'hFE);
    set_in(0, 0, 0, 3, 4, 0, 0, 0, 0);
    chk("add_written", bus.REGOUT1, 8'h0C);
    chk("sub_written", bus.REGOUT2, 8'hFE);

    // Wrap: 0xFF + 0x01
    load_imm(6, 8'hFF);
    load_imm(7, 8'h01);
    set_in(0, 1, 0, 6, 7, 0, 1, 0, 0);
    chk("add_wrap", bus.ALURESULT, 8'h00);

    // Negation corner cases: -0x80 and -0x00
    load_imm(6, 8'h80);
    set_in(0, 0, 0, 0, 6, 0, 0, 1, 0);
    chk("neg_80", bus.ALURESULT, 8'h80);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("neg_00", bus.ALURESULT, 8'h00);

    // Logic ops
    set_in(0, 0, 0, 1, 2, 0, 2, 0, 0);
    chk("and_05_07", bus.ALURESULT, 8'h05);
    set_in(0, 0, 0, 1, 0, 8'h0A, 3, 0, 1);
    chk("or_05_0a", bus.ALURESULT, 8'h0F);

    // MOV r5 <- r2
    set_in(0, 1, 5, 0, 2, 8'hEE, 0, 0, 0);
    set_in(0, 0, 0, 5, 0, 0, 0, 0, 0);
    chk("mov_r5", bus.REGOUT1, 8'h07);

    // Write gating: WE=0 with ADD into r5
    set_in(0, 0, 5, 1, 2, 0, 1, 0, 0);
    set_in(0, 0, 0, 5, 0, 0, 0, 0, 0);
    chk("we0_r5_kept", bus.REGOUT1, 8'h07);

    // Reserved opcode
    set_in(0, 0, 0, 1, 2, 8'h33, 5, 0, 1);
    chk("reserved_101", bus.ALURESULT, 8'h00);

    // Read-modify-write r1 = r1 + r1
    set_in(0, 1, 1, 1, 1, 0, 1, 0, 0);
    chk("rmw_pre_rd", bus.REGOUT1, 8'h05);
    chk("rmw_pre_alu", bus.ALURESULT, 8'h0A);
    set_in(0, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("rmw_post", bus.REGOUT1, 8'h0A);

    // Mid-sequence reset drops the pending write
    set_in(1, 1, 2, 1, 2, 8'h55, 0, 0, 1);
    set_in(0, 0, 0, 1, 2, 0, 0, 0, 0);
    chk("midreset_r1", bus.REGOUT1, 8'h00);
    chk("midreset_r2", bus.REGOUT2, 8'h00);

    @(negedge CLK);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
